branch_update_queue: RTL and testbench

- In-order queue of in-flight conditional branches between fetch and execute.
- Upstream of lab4_branch_BranchBimodal: records the PC and prediction of each branch at fetch.
- When execute resolves the oldest branch, it drives the predictor's update_en/update_val/PC-for-update one cycle later and flags a mispredict.
- On a mispredict it squashes all younger (wrong-path) entries.

---
 rtl/branch_update_queue.sv | 124 ++++++++++++
 tb/tb_branch_update_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight conditional branches. Records PC and fetch-time prediction,
// emits a registered predictor update when the oldest branch resolves, and flushes on mispredict.
module branch_update_queue #(
    parameter int NUM_ENTRIES = 4,
    parameter int PC_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alloc_val,
    output logic                               alloc_rdy,
    input  logic [PC_WIDTH-1:0]                alloc_pc,
    input  logic                               alloc_pred,
    input  logic                               resolve_val,
    output logic                               resolve_rdy,
    input  logic                               resolve_taken,
    output logic                               update_en,
    output logic                               update_val,
    output logic [PC_WIDTH-1:0]                update_pc,
    output logic                               mispredict,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   count
);

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PC_WIDTH-1:0]    pc_mem_r [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] pred_mem_r;
    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;
    logic [PTR_W-1:0]       head_nxt_s;
    logic [PTR_W-1:0]       tail_nxt_s;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_nxt_s;
    logic                   alloc_fire_s;
    logic                   resolve_fire_s;
    logic                   flush_s;
    logic [PC_WIDTH-1:0]    head_pc_s;
    logic                   head_pred_s;
    logic                   update_en_r;
    logic                   update_val_r;
    logic [PC_WIDTH-1:0]    update_pc_r;
    logic                   mispredict_r;

    assign alloc_rdy      = (count_r != FULL_CNT);
    assign resolve_rdy    = (count_r != ZERO_CNT);
    assign alloc_fire_s   = alloc_val & alloc_rdy;
    assign resolve_fire_s = resolve_val & resolve_rdy;
    assign head_pc_s      = pc_mem_r[head_r];
    assign head_pred_s    = pred_mem_r[head_r];
    assign flush_s        = resolve_fire_s & (head_pred_s != resolve_taken);

    assign update_en  = update_en_r;
    assign update_val = update_val_r;
    assign update_pc  = update_pc_r;
    assign mispredict = mispredict_r;
    assign count      = count_r;

    // Next pointer/occupancy; a flush collapses the queue onto the old tail, dropping any same-cycle alloc.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (flush_s) begin
            head_nxt_s  = tail_r;
            tail_nxt_s  = tail_r;
            count_nxt_s = ZERO_CNT;
        end else begin
            if (alloc_fire_s) begin
                tail_nxt_s = tail_r + PTR_ONE;
            end else begin
                tail_nxt_s = tail_r;
            end
            if (resolve_fire_s) begin
                head_nxt_s = head_r + PTR_ONE;
            end else begin
                head_nxt_s = head_r;
            end
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, alloc_fire_s}
                                  - {{(CNT_W-1){1'b0}}, resolve_fire_s};
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (alloc_fire_s) begin
            pc_mem_r[tail_r]   <= alloc_pc;
            pred_mem_r[tail_r] <= alloc_pred;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= ZERO_CNT;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Registered predictor update; PC and value hold between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            update_en_r  <= 1'b0;
            update_val_r <= 1'b0;
            update_pc_r  <= {PC_WIDTH{1'b0}};
            mispredict_r <= 1'b0;
        end else begin
            update_en_r  <= resolve_fire_s;
            mispredict_r <= flush_s;
            if (resolve_fire_s) begin
                update_val_r <= resolve_taken;
                update_pc_r  <= head_pc_s;
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_branch_update_queue;

    localparam int NUM = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_val;
    logic        alloc_rdy;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic        resolve_val;
    logic        resolve_rdy;
    logic        resolve_taken;
    logic        update_en;
    logic        update_val;
    logic [31:0] update_pc;
    logic        mispredict;
    logic [2:0]  count;

    ent_t        mq[$];
    logic        exp_en;
    logic        exp_val;
    logic [31:0] exp_pc;
    logic        exp_mp;
    int          total = 0;
    int          bad   = 0;

    branch_update_queue #(.NUM_ENTRIES(NUM), .PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .resolve_val(resolve_val), .resolve_rdy(resolve_rdy), .resolve_taken(resolve_taken),
        .update_en(update_en), .update_val(update_val), .update_pc(update_pc),
        .mispredict(mispredict), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk_eq("update_en",  {31'd0, update_en},  {31'd0, exp_en});
        chk_eq("update_val", {31'd0, update_val}, {31'd0, exp_val});
        chk_eq("update_pc",  update_pc,           exp_pc);
        chk_eq("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
    endtask

    // One cycle: drive, check ready/count against model, clock, update model, check outputs.
    task automatic step(input logic av, input logic [31:0] pc, input logic pr,
                        input logic rv, input logic tk);
        logic af;
        logic rf;
        logic mp;
        ent_t e;
        @(negedge clk);
        reset = 1'b0;
        alloc_val = av; alloc_pc = pc; alloc_pred = pr;
        resolve_val = rv; resolve_taken = tk;
        #1;
        chk_eq("alloc_rdy",   {31'd0, alloc_rdy},   (mq.size() != NUM) ? 32'd1 : 32'd0);
        chk_eq("resolve_rdy", {31'd0, resolve_rdy}, (mq.size() != 0) ? 32'd1 : 32'd0);
        chk_eq("count",       {29'd0, count},       mq.size());
        af = av && (mq.size() != NUM);
        rf = rv && (mq.size() != 0);
        mp = 1'b0;
        exp_en = 1'b0;
        exp_mp = 1'b0;
        if (rf) begin
            e = mq.pop_front();
            exp_en  = 1'b1;
            exp_val = tk;
            exp_pc  = e.pc;
            mp      = (e.pred != tk);
            exp_mp  = mp;
        end
        if (mp) mq.delete();
        else if (af) mq.push_back('{pc: pc, pred: pr});
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic rv);
        @(negedge clk);
        reset = 1'b1; alloc_val = 1'b0; resolve_val = rv; resolve_taken = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        exp_en = 1'b0; exp_val = 1'b0; exp_pc = 32'd0; exp_mp = 1'b0;
        chk_eq("rst_count", {29'd0, count}, 32'd0);
        check_outputs();
    endtask

    initial begin
        logic tk;
        logic pr;
        reset = 1'b1; alloc_val = 1'b0; alloc_pc = 32'd0; alloc_pred = 1'b0;
        resolve_val = 1'b0; resolve_taken = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b1);

        // Single branch, correctly predicted not-taken.
        step(1'b1, 32'h20C, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b0);
        chk_eq("t1_pc", update_pc, 32'h20C);
        chk_eq("t1_mp", {31'd0, mispredict}, 32'd0);

        // Three in-order updates.
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk_eq("t2_pc", update_pc, 32'h108);

        // Head mispredict flushes younger entries.
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk_eq("t3_mp", {31'd0, mispredict}, 32'd1);
        chk_eq("t3_pc", update_pc, 32'h100);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Full queue: no alloc, even alongside a resolve.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h280, 1'b1, 1'b1, 1'b1);
        chk_eq("t4_count", {29'd0, count}, 32'd3);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Mispredict with same-cycle alloc: the alloc is dropped.
        step(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk_eq("t5_pc", update_pc, 32'h400);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) begin
            pr = (i % 2) == 1;
            step(1'b1, 32'(i * 4), pr, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b1, pr);
            chk_eq("wrap_pc", update_pc, 32'(i * 4));
        end

        // Reset with two entries resident and a resolve pending.
        step(1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h604, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                pr = $urandom_range(0, 1) == 1;
                if (mq.size() != 0) tk = mq[0].pred ^ ($urandom_range(0, 5) == 0);
                else tk = $urandom_range(0, 1) == 1;
                step($urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC, pr,
                     $urandom_range(0, 1) == 1, tk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
